pe_time_seq: RTL and testbench

- Sigma-point sequencer. It is the driving and collecting end of the time-process PE interface (x_curr/x_curr_valid out, x_next/x_next_valid in).
- Flow:
  - Host loads NUM_SIGMA 160-bit state vectors into an input buffer.
  - On start, the block streams them back-to-back into the time-process PE.
  - It captures the propagated vectors in arrival order into an output buffer.
  - It pulses done when all have returned.
- Sits between the UKF sigma-point generator and the predicted-mean/covariance stage.

---
 rtl/pe_time_pkg.sv | 52 +++++
 rtl/pe_time_sp_buf.sv | 51 +++++
 rtl/pe_time_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_pe_time_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_time_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_time_pkg
// Description : Shared constants and types for the time-process sigma-point
//               sequencer. Contains the state-vector geometry (five 32-bit
//               fixed-point fields, xi in the MSBs), the default sigma-point
//               count and the sequencer FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_time_pkg;

    localparam int STATE_W       = 160;
    localparam int FIELD_W       = 32;

    // LSB offset of each field inside a state vector
    localparam int XI_LSB        = 128;
    localparam int XI_DOT_LSB    = 96;
    localparam int ETA_LSB       = 64;
    localparam int ETA_DOT_LSB   = 32;
    localparam int W_LSB         = 0;

    // 2n+1 sigma points for n = 5
    localparam int NUM_SIGMA_DEF = 11;

    localparam int CNT_W         = 5;
    localparam int ADDR_W        = 4;

    typedef logic [STATE_W-1:0] state_vec_t;
    typedef logic [FIELD_W-1:0] field_t;

    // Sequencer FSM encoding
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t S_IDLE  = 2'd0;
    localparam seq_state_t S_ISSUE = 2'd1;
    localparam seq_state_t S_DRAIN = 2'd2;
    localparam seq_state_t S_DONE  = 2'd3;

    // Extract one field: 0 = xi, 1 = xi_dot, 2 = eta, 3 = eta_dot, 4 = w
    function automatic field_t get_field(input state_vec_t v, input int unsigned sel);
        field_t f;
        case (sel)
            0:       f = v[XI_LSB      +: FIELD_W];
            1:       f = v[XI_DOT_LSB  +: FIELD_W];
            2:       f = v[ETA_LSB     +: FIELD_W];
            3:       f = v[ETA_DOT_LSB +: FIELD_W];
            default: f = v[W_LSB       +: FIELD_W];
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_time_sp_buf.sv
`default_nettype none
// ============================================================================
// Module      : pe_time_sp_buf
// Description : Small register file holding DEPTH state vectors. One
//               synchronous write port, one combinational read port.
//               Writes to an index >= DEPTH are dropped; reads of an index
//               >= DEPTH return zero. Contents are not reset.
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_addr  - write index
//               wr_data  - write data
//               rd_addr  - read index
//               rd_data  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module pe_time_sp_buf #(
    parameter int DEPTH = 11,
    parameter int WIDTH = 160
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [3:0]          rd_addr,
    output logic [WIDTH-1:0]    rd_data
);
    import pe_time_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Address decode is done per entry so that any DEPTH in 1..16 works
    // without index-width mismatches; out-of-range indices match nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                r_mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_time_seq.sv
`default_nettype none
// ============================================================================
// Module      : pe_time_seq
// Description : Sigma-point sequencer for the time-process PE. The host loads
//               NUM_SIGMA state vectors into an input buffer while idle; a
//               start request streams them back-to-back to the PE, the
//               propagated vectors are captured in arrival order into an
//               output buffer, and done pulses once all have returned.
// Options     : PE_TIME_SEQ_TIMEOUT_EN - adds a DRAIN watchdog that ends the
//               run after TIMEOUT capture-free cycles and flags timeout.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - run request (honoured in IDLE only)
//               busy, done, timeout - run status
//               sp_wr_en/addr/data  - input-buffer load port
//               rd_addr, rd_data    - output-buffer read port (1-cycle)
//               pe_en_clk           - PE clock enable
//               pe_x_curr(_valid)   - vector stream to the PE
//               pe_x_next(_valid)   - propagated vectors from the PE
// Revision    : 1.0 - initial release
// ============================================================================
module pe_time_seq #(
    parameter int NUM_SIGMA = pe_time_pkg::NUM_SIGMA_DEF,
    parameter int STATE_W   = pe_time_pkg::STATE_W,
    parameter int TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    input  logic                sp_wr_en,
    input  logic [3:0]          sp_wr_addr,
    input  logic [STATE_W-1:0]  sp_wr_data,
    input  logic [3:0]          rd_addr,
    output logic [STATE_W-1:0]  rd_data,
    output logic                pe_en_clk,
    output logic [STATE_W-1:0]  pe_x_curr,
    output logic                pe_x_curr_valid,
    input  logic [STATE_W-1:0]  pe_x_next,
    input  logic                pe_x_next_valid
);
    import pe_time_pkg::*;

    localparam logic [CNT_W-1:0] RX_LIM  = CNT_W'(NUM_SIGMA);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(NUM_SIGMA - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_tx_cnt;
    logic [CNT_W-1:0]   r_rx_cnt;
    logic [CNT_W-1:0]   w_tx_next;
    logic               w_cap;
    logic               w_wd_expire;
    logic [STATE_W-1:0] w_in_rd;
    logic [STATE_W-1:0] w_out_rd;

    // The PE runs whenever we are out of reset so its pipeline always drains.
    assign pe_en_clk = ~rst;

    // Capture any PE result while a run is active, up to NUM_SIGMA of them.
    assign w_cap = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) &&
                   pe_x_next_valid && (r_rx_cnt < RX_LIM);

    // Index of the vector presented after the coming edge: 0 when a run
    // starts, tx_cnt+1 while issuing. Upper bit is never needed as an address.
    assign w_tx_next = (r_state == S_ISSUE) ? (r_tx_cnt + CNT_W'(1)) : '0;

    // ------------------------------------------------------------------
    // Buffers
    // ------------------------------------------------------------------
    pe_time_sp_buf #(
        .DEPTH   (NUM_SIGMA),
        .WIDTH   (STATE_W)
    ) u_in_buf (
        .clk     (clk),
        .wr_en   (sp_wr_en && (r_state == S_IDLE)),
        .wr_addr (sp_wr_addr),
        .wr_data (sp_wr_data),
        .rd_addr (w_tx_next[ADDR_W-1:0]),
        .rd_data (w_in_rd)
    );

    pe_time_sp_buf #(
        .DEPTH   (NUM_SIGMA),
        .WIDTH   (STATE_W)
    ) u_out_buf (
        .clk     (clk),
        .wr_en   (w_cap),
        .wr_addr (r_rx_cnt[ADDR_W-1:0]),
        .wr_data (pe_x_next),
        .rd_addr (rd_addr),
        .rd_data (w_out_rd)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_tx_cnt == TX_LAST) w_state_nxt = S_DRAIN;
            // rx_cnt is the registered count, so a last capture made during
            // ISSUE still leaves one DRAIN cycle before DONE.
            S_DRAIN: if ((r_rx_cnt == RX_LIM) || w_wd_expire) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        done = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: issue stream, counters, read register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt        <= '0;
            r_rx_cnt        <= '0;
            pe_x_curr       <= '0;
            pe_x_curr_valid <= 1'b0;
            rd_data         <= '0;
        end else begin
            rd_data <= w_out_rd;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // First vector goes out on the edge that accepts start.
                        r_tx_cnt        <= '0;
                        r_rx_cnt        <= '0;
                        pe_x_curr       <= w_in_rd;
                        pe_x_curr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_tx_cnt == TX_LAST) begin
                        // pe_x_curr keeps the last vector through DRAIN
                        pe_x_curr_valid <= 1'b0;
                    end else begin
                        r_tx_cnt        <= w_tx_next;
                        pe_x_curr       <= w_in_rd;
                        pe_x_curr_valid <= 1'b1;
                    end
                end
                default: begin
                    pe_x_curr_valid <= 1'b0;
                end
            endcase

            if (w_cap) begin
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional DRAIN watchdog
    // ------------------------------------------------------------------
`ifdef PE_TIME_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wdog;

    // Held at zero while issuing so it starts from zero on DRAIN entry; any
    // capture restarts the count, so the limit is measured from the last
    // returned vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == S_DRAIN) begin
            if (w_cap) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WD_W'(1);
            end
        end else begin
            r_wdog <= '0;
        end
    end

    // Normal completion takes precedence over an expiry in the same cycle.
    assign w_wd_expire = (r_state == S_DRAIN) && !w_cap &&
                         (r_rx_cnt != RX_LIM) &&
                         (r_wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            timeout <= 1'b0;
        end else if (w_wd_expire) begin
            timeout <= 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_wd_expire          = 1'b0;
    assign timeout              = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_time_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_time_seq
// Description : Directed bench for pe_time_seq. Drives a behavioural PE with
//               selectable latency, runs a table of sequencer runs with
//               hand-computed completion cycles, then hand-written sequences
//               for idle-time noise, reset mid-drain and (when built with
//               PE_TIME_SEQ_TIMEOUT_EN) a dropped point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_time_seq;
    import pe_time_pkg::*;

    localparam int NS = 11;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic               timeout;
    logic               sp_wr_en;
    logic [3:0]         sp_wr_addr;
    logic [STATE_W-1:0] sp_wr_data;
    logic [3:0]         rd_addr;
    logic [STATE_W-1:0] rd_data;
    logic               pe_en_clk;
    logic [STATE_W-1:0] pe_x_curr;
    logic               pe_x_curr_valid;
    logic [STATE_W-1:0] pe_x_next;
    logic               pe_x_next_valid;

    int n_checks = 0;
    int n_err    = 0;

    pe_time_seq #(
        .NUM_SIGMA (NS),
        .STATE_W   (STATE_W),
        .TIMEOUT   (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .sp_wr_en        (sp_wr_en),
        .sp_wr_addr      (sp_wr_addr),
        .sp_wr_data      (sp_wr_data),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .pe_en_clk       (pe_en_clk),
        .pe_x_curr       (pe_x_curr),
        .pe_x_curr_valid (pe_x_curr_valid),
        .pe_x_next       (pe_x_next),
        .pe_x_next_valid (pe_x_next_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference functions
    // ------------------------------------------------------------------
    function automatic state_vec_t mk_point(input int i);
        logic [31:0] f;
        f = 32'(i);
        return {f, f, f, f, f};
    endfunction

    // Stand-in for the time-process update
    function automatic state_vec_t pe_fn(input state_vec_t x);
        field_t a, b, c, d, e;
        a = get_field(x, 0);
        b = get_field(x, 1);
        c = get_field(x, 2);
        d = get_field(x, 3);
        e = get_field(x, 4);
        return {a + b, b + 32'd1, c ^ d, d + 32'h100, e * 32'd3};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural PE: pe_lat-stage pipeline (0 = combinational)
    // ------------------------------------------------------------------
    int         pe_lat  = 0;
    bit         drop_en = 1'b0;
    logic       inj_v;
    state_vec_t inj_d;
    state_vec_t pipe_d [0:31];
    logic       pipe_v [0:31];
    logic       m_in_v;
    logic       m_v;
    state_vec_t m_d;

    assign m_in_v = pe_x_curr_valid && !(drop_en && (pe_x_curr == mk_point(7)));

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 32; s++) begin
                pipe_v[s] <= 1'b0;
                pipe_d[s] <= '0;
            end
        end else begin
            pipe_v[0] <= m_in_v;
            pipe_d[0] <= pe_fn(pe_x_curr);
            for (int s = 1; s < 32; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_d[s] <= pipe_d[s-1];
            end
        end
    end

    always_comb begin
        m_v = 1'b0;
        m_d = '0;
        if (pe_lat == 0) begin
            m_v = m_in_v;
            m_d = pe_fn(pe_x_curr);
        end else begin
            m_v = pipe_v[pe_lat-1];
            m_d = pipe_d[pe_lat-1];
        end
        pe_x_next_valid = m_v | inj_v;
        pe_x_next       = inj_v ? inj_d : m_d;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input state_vec_t act, input state_vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick();
            chk($sformatf("%s rd_data[%0d]", tag, i), rd_data,
                (i < NS) ? pe_fn(mk_point(i)) : '0);
        end
    endtask

    // One run. Sample j is taken 1 time unit after edge k+j, where edge k
    // accepts start. exp_done is the sample index at which done is seen.
    task automatic run_one(input int lat, input int exp_done, input bit disturb, input bit drop);
        int done_j;
        int done_cnt;
        pe_lat  = lat;
        drop_en = drop;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        done_j   = -1;
        done_cnt = 0;
        for (int j = 0; j <= exp_done + 3; j++) begin
            if (j == 0) chk("timeout cleared on start", timeout, 1'b0);
            if (j < NS) begin
                chk($sformatf("lat%0d valid j=%0d", lat, j), pe_x_curr_valid, 1'b1);
                chk($sformatf("lat%0d x_curr j=%0d", lat, j), pe_x_curr, mk_point(j));
            end else begin
                chk($sformatf("lat%0d valid low j=%0d", lat, j), pe_x_curr_valid, 1'b0);
            end
            if (done) begin
                done_cnt++;
                if (done_j < 0) done_j = j;
                chk($sformatf("lat%0d busy on done", lat), busy, 1'b0);
                chk($sformatf("lat%0d timeout at done", lat), timeout, drop);
            end else begin
                chk($sformatf("lat%0d busy j=%0d", lat, j), busy, (j < exp_done));
            end
            // stimulus for the next edge
            start      = disturb && ((j == 3) || (j == exp_done));
            sp_wr_en   = disturb && (j == NS);
            sp_wr_addr = 4'd2;
            sp_wr_data = '1;
            inj_v      = !drop && (j == NS + lat);
            inj_d      = {5{32'hDEAD_BEEF}};
            tick();
        end
        start    = 1'b0;
        sp_wr_en = 1'b0;
        inj_v    = 1'b0;
        chk($sformatf("lat%0d done cycle", lat), 32'(done_j), 32'(exp_done));
        chk($sformatf("lat%0d done count", lat), 32'(done_cnt), 32'd1);
        if (!drop) readback_all($sformatf("lat%0d", lat));
    endtask

    // ------------------------------------------------------------------
    // Run table: done sample index = NS + lat + 1 (last capture, then one
    // DRAIN cycle seeing the full count, then DONE).
    // ------------------------------------------------------------------
    typedef struct {
        int lat;
        int exp_done;
        bit disturb;
    } run_vec_t;

    run_vec_t vecs [4];

    initial begin
        vecs[0] = '{lat: 3,  exp_done: 15, disturb: 1'b0};
        vecs[1] = '{lat: 0,  exp_done: 12, disturb: 1'b1};
        vecs[2] = '{lat: 20, exp_done: 32, disturb: 1'b1};
        vecs[3] = '{lat: 7,  exp_done: 19, disturb: 1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        sp_wr_en   = 1'b0;
        sp_wr_addr = '0;
        sp_wr_data = '0;
        rd_addr    = '0;
        inj_v      = 1'b0;
        inj_d      = '0;

        tick();
        tick();
        chk("reset busy",      busy,            1'b0);
        chk("reset done",      done,            1'b0);
        chk("reset timeout",   timeout,         1'b0);
        chk("reset valid",     pe_x_curr_valid, 1'b0);
        chk("reset x_curr",    pe_x_curr,       '0);
        chk("reset rd_data",   rd_data,         '0);
        chk("reset pe_en_clk", pe_en_clk,       1'b0);
        rst = 1'b0;
        tick();
        chk("pe_en_clk after reset", pe_en_clk, 1'b1);

        // Load sigma points; index 12 is out of range and must be dropped
        for (int i = 0; i < NS; i++) begin
            sp_wr_en   = 1'b1;
            sp_wr_addr = 4'(i);
            sp_wr_data = mk_point(i);
            tick();
        end
        sp_wr_addr = 4'd12;
        sp_wr_data = '1;
        tick();
        sp_wr_en = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_one(vecs[v].lat, vecs[v].exp_done, vecs[v].disturb, 1'b0);
            tick();
        end

        // Spurious PE valids while idle must not touch the output buffer
        inj_v = 1'b1;
        inj_d = {5{32'h0BAD_0BAD}};
        tick();
        tick();
        inj_v = 1'b0;
        chk("idle noise busy", busy, 1'b0);
        readback_all("idle noise");

        // Reset in DRAIN after five captures (lat 20: captures at edges k+21..)
        pe_lat = 20;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int j = 0; j < 25; j++) tick();
        chk("mid-drain busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("post-rst busy",      busy,            1'b0);
        chk("post-rst done",      done,            1'b0);
        chk("post-rst valid",     pe_x_curr_valid, 1'b0);
        chk("post-rst pe_en_clk", pe_en_clk,       1'b0);
        rst = 1'b0;
        tick();
        chk("post-rst idle done", done, 1'b0);
        chk("post-rst pe_en_clk", pe_en_clk, 1'b1);
        tick();
        run_one(3, 15, 1'b0, 1'b0);
        tick();

`ifdef PE_TIME_SEQ_TIMEOUT_EN
        // Point 7 is lost: last capture (point 10, lat 3) at edge k+14,
        // watchdog ends the run 64 cycles later.
        run_one(3, 78, 1'b0, 1'b1);
        tick();
        drop_en = 1'b0;
        run_one(3, 15, 1'b0, 1'b0);
`else
        chk("timeout tied low", timeout, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
